// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bus address map, master limit and arbiter state encoding
package cpu_bus_pkg;
    localparam int MAX_MASTERS = 4;
    localparam logic [31:0] BIOS_BASE    = 32'hbfc0_0000;
    localparam logic [31:0] BIOS_MASK    = 32'hfff0_0000;
    localparam logic [31:0] CVRAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] CVRAM_MASK   = 32'hffff_f000;
    localparam logic [31:0] GVRAM_BASE   = 32'h8010_0000;
    localparam logic [31:0] GVRAM_MASK   = 32'hfff0_0000;
    localparam logic [31:0] GPIO_BASE    = 32'h9000_0000;
    localparam logic [31:0] GPIO_MASK    = 32'hffff_ff00;
    localparam logic [31:0] SD_CTRL_BASE = 32'h9000_1000;
    localparam logic [31:0] SD_CTRL_MASK = 32'hffff_ff00;
    localparam logic [31:0] SD_DATA_BASE = 32'h9000_2000;
    localparam logic [31:0] SD_DATA_MASK = 32'hffff_f000;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
endpackage

// File: rtl/cpu_bus_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request at or after ptr (mod N) as one-hot grant plus index
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: round-robin bus arbiter with burst lock, forced release and read-return routing
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MAX_HOLD    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [NUM_MASTERS-1:0]    m_lock,
    input  logic [NUM_MASTERS*32-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*32-1:0] m_wdata,
    input  logic [NUM_MASTERS*4-1:0]  m_wmask,
    output logic [NUM_MASTERS-1:0]    m_gnt,
    output logic [NUM_MASTERS-1:0]    m_rvalid,
    output logic [31:0]               m_rdata,
    output logic [31:0]               addrBus,
    output logic                      masterEN,
    output logic                      weBus,
    output logic [31:0]               wdataBus,
    output logic [3:0]                wmaskBus,
    input  logic [31:0]               dataToCPU
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    arb_state_t state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, rd_idx_q, rd_idx_d, gidx, start;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic rd_pend_q, rd_pend_d;
    logic [NUM_MASTERS-1:0] elig;
    rr_priority_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req(elig),
        .ptr(start),
        .gnt(m_gnt),
        .idx(gidx)
    );
    always_comb begin
        elig = state_q == ARB_LOCKED ? m_req & (NUM_MASTERS'(1) << owner_q) : m_req;
        start = state_q == ARB_LOCKED ? owner_q : rr_ptr_q;
        masterEN = |m_gnt;
        addrBus = masterEN ? m_addr[32*gidx +: 32] : '0;
        wdataBus = masterEN ? m_wdata[32*gidx +: 32] : '0;
        wmaskBus = masterEN ? m_wmask[4*gidx +: 4] : '0;
        weBus = masterEN & m_we[gidx];
        m_rvalid = rd_pend_q ? NUM_MASTERS'(1) << rd_idx_q : '0;
        m_rdata = rd_pend_q ? dataToCPU : '0;
        rd_pend_d = masterEN & ~m_we[gidx];
        rd_idx_d = gidx;
        rr_ptr_d = !masterEN ? rr_ptr_q : gidx == IW'(NUM_MASTERS - 1) ? '0 : gidx + IW'(1);
        hold_inc = hold_cnt_q + HW'(1);
        state_d = state_q;
        owner_d = owner_q;
        hold_cnt_d = hold_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (masterEN && m_lock[gidx]) begin
                state_d = ARB_LOCKED;
                owner_d = gidx;
                hold_cnt_d = HW'(1);
            end
        end else if (!masterEN) begin
            state_d = ARB_IDLE;
        end else begin
            hold_cnt_d = hold_inc;
            state_d = (!m_lock[owner_q] || hold_inc == HW'(MAX_HOLD)) ? ARB_IDLE : ARB_LOCKED;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q <= '0;
            hold_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q <= rd_idx_d;
        end
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed vector table plus hand sequences for lock, forced release, write and reset
module tb_cpu_bus_arbiter;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] m_req, m_lock, m_we, m_gnt, m_rvalid;
    logic [N*32-1:0] m_addr, m_wdata;
    logic [N*4-1:0] m_wmask;
    logic [31:0] m_rdata, addrBus, wdataBus, dataToCPU;
    logic masterEN, weBus;
    logic [3:0] wmaskBus;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] we;
        logic [N-1:0] gnt;
        logic [N-1:0] rv;
    } vec_t;
    vec_t tbl[$];

    cpu_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr), .m_we(m_we),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .addrBus(addrBus), .masterEN(masterEN), .weBus(weBus), .wdataBus(wdataBus),
        .wmaskBus(wmaskBus), .dataToCPU(dataToCPU)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [N-1:0] we);
        m_req = req;
        m_lock = lock;
        m_we = we;
        cyc++;
        dataToCPU = 32'hDA7A_0000 + 32'(cyc);
    endtask

    task automatic outs(input string tag, input logic [N-1:0] g, input logic [N-1:0] rv);
        logic [31:0] ea, ed;
        logic [3:0] em;
        ea = '0;
        ed = '0;
        em = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                ea = m_addr[32*i +: 32];
                ed = m_wdata[32*i +: 32];
                em = m_wmask[4*i +: 4];
            end
        end
        chk({tag, " m_gnt"}, 32'(m_gnt), 32'(g));
        chk({tag, " m_rvalid"}, 32'(m_rvalid), 32'(rv));
        chk({tag, " masterEN"}, 32'(masterEN), 32'(|g));
        chk({tag, " weBus"}, 32'(weBus), 32'(|(g & m_we)));
        chk({tag, " addrBus"}, addrBus, ea);
        chk({tag, " wdataBus"}, wdataBus, ed);
        chk({tag, " wmaskBus"}, 32'(wmaskBus), 32'(em));
        chk({tag, " m_rdata"}, m_rdata, rv != '0 ? dataToCPU : 32'h0);
    endtask

    task automatic cyc_chk(input string tag, input logic [N-1:0] g, input logic [N-1:0] rv);
        @(negedge clk);
        outs(tag, g, rv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] eg, prev;
        m_req = '0;
        m_lock = '0;
        m_we = '0;
        dataToCPU = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) begin
            m_addr[32*i +: 32] = 32'h1000_0000 * (i + 1) + 32'(i * 4);
            m_wdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
            m_wmask[4*i +: 4] = 4'(i + 1);
        end
        //           req      lock     we       gnt      rv
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b001, 3'b000});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b010, 3'b001});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b100, 3'b010});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b001, 3'b100});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b010, 3'b001});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b100, 3'b010});
        tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b001, 3'b100});
        tbl.push_back('{3'b111, 3'b010, 3'b000, 3'b010, 3'b001});
        tbl.push_back('{3'b111, 3'b010, 3'b000, 3'b010, 3'b010});
        tbl.push_back('{3'b111, 3'b010, 3'b000, 3'b010, 3'b010});
        tbl.push_back('{3'b111, 3'b010, 3'b000, 3'b010, 3'b010});
        tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b010, 3'b010});
        tbl.push_back('{3'b101, 3'b000, 3'b000, 3'b100, 3'b010});
        tbl.push_back('{3'b001, 3'b000, 3'b111, 3'b001, 3'b100});
        tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{3'b001, 3'b001, 3'b000, 3'b001, 3'b000});
        tbl.push_back('{3'b100, 3'b001, 3'b000, 3'b000, 3'b001});
        tbl.push_back('{3'b100, 3'b000, 3'b000, 3'b100, 3'b000});
        tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 3'b100});

        repeat (2) @(posedge clk);
        #1;
        outs("reset", 3'b000, 3'b000);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].lock, tbl[i].we);
            cyc_chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].rv);
        end

        prev = '0;
        for (int k = 0; k < 18; k++) begin
            eg = (k < 16) ? 3'b001 : (k == 16) ? 3'b100 : 3'b001;
            apply(3'b101, 3'b001, 3'b000);
            cyc_chk($sformatf("hold%0d", k), eg, prev);
            prev = eg;
        end
        apply(3'b000, 3'b000, 3'b000);
        cyc_chk("hold_drop", 3'b000, prev);

        m_addr[64 +: 32] = 32'hbfc0_9004;
        m_wdata[64 +: 32] = 32'h0000_A5A5;
        m_wmask[8 +: 4] = 4'b0011;
        apply(3'b100, 3'b000, 3'b100);
        @(negedge clk);
        chk("wr addrBus", addrBus, 32'hbfc0_9004);
        chk("wr wdataBus", wdataBus, 32'h0000_A5A5);
        chk("wr wmaskBus", 32'(wmaskBus), 32'h3);
        chk("wr weBus", 32'(weBus), 32'h1);
        chk("wr masterEN", 32'(masterEN), 32'h1);
        chk("wr m_gnt", 32'(m_gnt), 32'h4);
        @(posedge clk);
        #1;
        apply(3'b000, 3'b000, 3'b000);
        cyc_chk("wr_after", 3'b000, 3'b000);

        apply(3'b010, 3'b000, 3'b000);
        cyc_chk("rd_before_rst", 3'b010, 3'b000);
        rst = 1'b1;
        m_req = '0;
        #1;
        chk("rst m_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst m_gnt", 32'(m_gnt), 32'h0);
        chk("rst masterEN", 32'(masterEN), 32'h0);
        chk("rst m_rdata", m_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(3'b111, 3'b000, 3'b000);
        cyc_chk("post_rst_rr", 3'b001, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
